vc_test_mem_responder: RTL

- Single-port memory responder: the target end of the vc-MemReqMsg/vc-MemRespMsg protocol that the PARCv2 core drives on its imem and dmem ports.
- Accepts request messages with a val/rdy handshake and returns in-order response messages with val only. The requester must always accept responses.
- Backs a word array. Provides a fixed-latency response pipeline and a preload port for test harnesses.
- Two instances serve one core (imem and dmem) in simulators and integration benches.

---
 rtl/vc_test_mem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vc_test_mem_responder.sv
// Word-array memory target for the vc-MemReqMsg/MemRespMsg protocol.
// Define VC_TEST_MEM_RAND_STALL_EN to add LFSR-driven random request stalls.
module vc_test_mem_responder #(
  parameter int          ADDR_BITS = 12,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [66:0]          memreq_msg,
  input  logic                 memreq_val,
  output logic                 memreq_rdy,
  output logic [34:0]          memresp_msg,
  output logic                 memresp_val,
  input  logic                 mem_load_en,
  input  logic [ADDR_BITS-1:0] mem_load_addr,
  input  logic [31:0]          mem_load_data
);

  typedef struct packed {
    logic        val;
    logic        typ;
    logic [1:0]  len;
    logic [31:0] data;
  } resp_t;

  logic [31:0] mem [2**ADDR_BITS];

  logic                 is_wr;
  logic [31:0]          addr;
  logic [1:0]           len;
  logic [31:0]          data;
  logic [ADDR_BITS-1:0] idx;
  logic [1:0]           off;
  logic [4:0]           sh;
  logic                 fire;
  logic                 stall;
  logic                 unused_ok;

  assign is_wr = memreq_msg[66];
  assign addr  = memreq_msg[65:34];
  assign len   = memreq_msg[33:32];
  assign data  = memreq_msg[31:0];
  assign idx   = addr[ADDR_BITS+1:2];
  assign off   = addr[1:0];
  assign sh    = {off, 3'b000};

  assign unused_ok = ^addr[31:ADDR_BITS+2];

`ifdef VC_TEST_MEM_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0],
               lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign memreq_rdy = !reset && !mem_load_en && !stall;
  assign fire       = memreq_val && memreq_rdy;

  logic [31:0] word;
  logic [31:0] dmask;
  logic [3:0]  bm;
  logic [7:0]  bm_sh;
  logic [31:0] wmask;
  logic [31:0] wbits;
  logic [31:0] wdata;
  logic [31:0] rdata;
  resp_t       nxt;

  assign word = mem[idx];

  always_comb begin
    dmask = 32'hFFFF_FFFF;
    bm    = 4'hF;
    unique case (len)
      2'd1: begin dmask = 32'h0000_00FF; bm = 4'h1; end
      2'd2: begin dmask = 32'h0000_FFFF; bm = 4'h3; end
      2'd3: begin dmask = 32'h00FF_FFFF; bm = 4'h7; end
      default: begin dmask = 32'hFFFF_FFFF; bm = 4'hF; end
    endcase
    // Bytes shifted past the word boundary fall off the top
    bm_sh = {4'b0000, bm} << off;
    for (int b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{bm_sh[b]}};
    end
    wbits = (data & dmask) << sh;
    wdata = (word & ~wmask) | (wbits & wmask);
    rdata = (word >> sh) & dmask;
    nxt   = '0;
    if (fire) begin
      nxt.val  = 1'b1;
      nxt.typ  = is_wr;
      nxt.len  = len;
      nxt.data = is_wr ? 32'h0 : rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_load_en) begin
      mem[mem_load_addr] <= mem_load_data;
    end else if (fire && is_wr) begin
      mem[idx] <= wdata;
    end
  end

  resp_t pipe [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= nxt;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign memresp_val = pipe[LATENCY-1].val;
  assign memresp_msg = {pipe[LATENCY-1].typ,
                        pipe[LATENCY-1].len,
                        pipe[LATENCY-1].data};

endmodule
